random_button_gen: RTL and testbench
====================================

# random_button_gen

Pseudo-random button source for the single-player game mode. A 16-bit Galois LFSR runs on the game-frame clock and drives a 4-bit vector of virtual button presses. Each bit is an attack, left or right input for the computer-controlled player FSM. The block sits between the frame clock domain and the player-2 FSM inputs and has no other dependencies.

## Interface
- WIDTH, 16, LFSR state width (fixed at 16 for the default taps; other widths need a matching TAPS)
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1, maximal length)
- SEED, 16'hACE1, reset and lock-up reload value; must be non-zero
- HOLD_FRAMES, 1, number of enabled cycles that each sampled output nibble is held (1..255)

- clk_game  in  1  game-frame clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- enable  in  1  advance LFSR and hold counter when high; freeze everything when low
- bits  out  4  virtual buttons: [0] spare, [1] left, [2] attack, [3] right

## Operation
- State register `lfsr[WIDTH-1:0]`. Each step is a right shift: `next = lfsr >> 1`, then if `lfsr[0]==1`, `next ^= TAPS`.
- Lock-up guard: if `lfsr` is ever all-zero, the next enabled step loads SEED instead of shifting. With a legal SEED this cannot occur; the guard covers SEU and bad parameters.
- Period with the default parameters is 65535 enabled steps.
- Hold counter `hold_cnt` is 8 bits and counts 0..HOLD_FRAMES-1:
  - On each enabled cycle: `lfsr <= next`.
  - If `hold_cnt == HOLD_FRAMES-1`: `bits <= next[3:0]` and `hold_cnt <= 0`.
  - Otherwise: `hold_cnt <= hold_cnt + 1` and `bits` is held.
- With HOLD_FRAMES=1, `bits` always equals `lfsr[3:0]`.
- enable low: `lfsr`, `hold_cnt` and `bits` all hold their values.
- No combinational path from any input to `bits`; `bits` is a register output.

## Timing
- Reset values: `lfsr=SEED`, `hold_cnt=0`, `bits=SEED[3:0]` (4'h1 by default).
- Reset asserted mid-sequence returns all registers to their reset values asynchronously.
- The first update occurs on the first rising edge of clk_game after reset deasserts with enable high.
- Latency is one cycle from an enabled edge to the new `bits` value (when the hold counter expires on that edge).
- Default bits sequence from reset: 1, 0, 8, C, E, 7, 3, ...
- Matching lfsr sequence: ACE1, E270, 7138, 389C, 1C4E, 0E27, B313.
- Simultaneous reset and enable: reset wins.

## Structure
- Shared game package holds:
  - the button-bit index constants BTN_LEFT=1, BTN_ATTACK=2, BTN_RIGHT=3;
  - the default LFSR constants (TAPS, SEED).
- One natural sub-module, `galois_lfsr`:
  - parameters WIDTH, TAPS, SEED;
  - ports clk_game, reset, step, state;
  - contains the lock-up guard.
- The top level adds the hold counter and the output register.
- Include elaboration checks that SEED != 0 and that HOLD_FRAMES is in 1..255.

## Test plan
- Reset then enable=1, HOLD_FRAMES=1, for 6 cycles -> bits = 1,0,8,C,E,7,3 and lfsr ends at B313.
- enable=0 for 10 cycles mid-sequence -> bits and lfsr unchanged. On re-enable the sequence resumes from the next value with no skipped step.
- Assert reset asynchronously between clock edges after 100 steps -> bits=4'h1 and lfsr=ACE1 before the next edge.
- HOLD_FRAMES=4, enable=1 -> bits changes only every 4th edge, taking lfsr[3:0] at that edge. First change is to 4'hE (lfsr=1C4E after 4 steps).
- Run 65535 enabled steps from reset -> lfsr returns to ACE1 for the first time and never reads 0.
- Force lfsr to 0 via test hook, then one enabled step -> lfsr=ACE1.

Source files
------------

// File: rtl/random_button_gen_pkg.sv
// Shared game constants: virtual button bit positions and default LFSR setup.
package random_button_gen_pkg;

    localparam int unsigned BTN_SPARE  = 0;
    localparam int unsigned BTN_LEFT   = 1;
    localparam int unsigned BTN_ATTACK = 2;
    localparam int unsigned BTN_RIGHT  = 3;

    localparam int unsigned LFSR_WIDTH = 16;
    // x^16 + x^14 + x^13 + x^11 + 1, maximal length
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

endpackage

// File: rtl/random_button_gen_lfsr.sv
// Right-shifting Galois LFSR with a reload-from-seed guard against the all-zero lock-up state.
module galois_lfsr #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk_game,
    input  logic             reset,
    input  logic             step,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_state >> 1;
        if (r_state[0]) begin
            w_next = w_next ^ TAPS;
        end
        // All-zero is a fixed point of the shift; only an upset can land here.
        if (r_state == '0) begin
            w_next = SEED;
        end
    end

    always_ff @(posedge clk_game or posedge reset) begin
        if (reset) begin
            r_state <= SEED;
        end else if (step) begin
            r_state <= w_next;
        end
    end

    assign state      = r_state;
    assign next_state = w_next;

endmodule

// File: rtl/random_button_gen.sv
// Pseudo-random virtual button source for the computer-controlled player; each sampled nibble
// of the LFSR is held for HOLD_FRAMES enabled frames.
module random_button_gen
    import random_button_gen_pkg::*;
#(
    parameter int unsigned      WIDTH       = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(LFSR_TAPS),
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(LFSR_SEED),
    parameter int unsigned      HOLD_FRAMES = 1
) (
    input  logic       clk_game,
    input  logic       reset,
    input  logic       enable,
    output logic [3:0] bits
);

    if (SEED == '0) begin : g_bad_seed
        $fatal(1, "random_button_gen: SEED must be non-zero");
    end
    if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
        $fatal(1, "random_button_gen: HOLD_FRAMES must be in 1..255");
    end
    if (WIDTH < 4) begin : g_bad_width
        $fatal(1, "random_button_gen: WIDTH must be at least 4");
    end

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

    logic [WIDTH-1:0] w_lfsr_state;
    logic [WIDTH-1:0] w_lfsr_next;
    logic [7:0]       r_hold_cnt;
    logic [3:0]       r_bits;
    logic             w_hold_done;

    galois_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk_game   (clk_game),
        .reset      (reset),
        .step       (enable),
        .state      (w_lfsr_state),
        .next_state (w_lfsr_next)
    );

    assign w_hold_done = (r_hold_cnt == HOLD_LAST);

    // Sample the value the LFSR moves to on this edge, so HOLD_FRAMES=1 tracks lfsr[3:0].
    always_ff @(posedge clk_game or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= '0;
            r_bits     <= SEED[3:0];
        end else if (enable) begin
            if (w_hold_done) begin
                r_hold_cnt <= '0;
                r_bits     <= w_lfsr_next[3:0];
            end else begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    assign bits = r_bits;

endmodule

// File: tb/tb_random_button_gen.sv
// Bench for random_button_gen: HOLD_FRAMES=1 and HOLD_FRAMES=4 instances side by side,
// expected nibbles queued from a reference LFSR model.
module tb_random_button_gen;

    logic       clk_game = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] bits1;
    logic [3:0] bits4;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_lfsr;
    logic [7:0]  m_hold;
    logic [3:0]  m_bits4;
    logic [3:0]  q1[$];
    logic [3:0]  q4[$];

    always #5 clk_game = ~clk_game;

    random_button_gen #(.HOLD_FRAMES(1)) dut1 (
        .clk_game (clk_game),
        .reset    (reset),
        .enable   (enable),
        .bits     (bits1)
    );

    random_button_gen #(.HOLD_FRAMES(4)) dut4 (
        .clk_game (clk_game),
        .reset    (reset),
        .enable   (enable),
        .bits     (bits4)
    );

    function automatic logic [15:0] ref_next(input logic [15:0] s);
        if (s == 16'h0) return 16'hACE1;
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_hold  = 8'd0;
        m_bits4 = 4'h1;
        q1.delete();
        q4.delete();
    endtask

    // One enabled edge: queue what each instance should show, then pop and compare.
    task automatic step_en();
        enable = 1'b1;
        m_lfsr = ref_next(m_lfsr);
        if (m_hold == 8'd3) begin
            m_bits4 = m_lfsr[3:0];
            m_hold  = 8'd0;
        end else begin
            m_hold = m_hold + 8'd1;
        end
        q1.push_back(m_lfsr[3:0]);
        q4.push_back(m_bits4);
        @(posedge clk_game);
        #1;
        chk("bits_hold1", {12'h0, bits1}, {12'h0, q1.pop_front()});
        chk("bits_hold4", {12'h0, bits4}, {12'h0, q4.pop_front()});
        chk("lfsr", dut1.w_lfsr_state, m_lfsr);
    endtask

    initial begin
        logic [3:0] seq [6];
        int         first_ret;
        int         zeros;

        seq = '{4'h0, 4'h8, 4'hC, 4'hE, 4'h7, 4'h3};

        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clk_game);
        #1;
        model_reset();
        chk("rst_bits1", {12'h0, bits1}, 16'h0001);
        chk("rst_bits4", {12'h0, bits4}, 16'h0001);
        chk("rst_lfsr", dut1.w_lfsr_state, 16'hACE1);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            step_en();
            chk("seq_bits", {12'h0, bits1}, {12'h0, seq[i]});
            if (i == 2) chk("hold4_still", {12'h0, bits4}, 16'h0001);
            if (i == 3) chk("hold4_first", {12'h0, bits4}, 16'h000E);
        end
        chk("seq_lfsr_end", dut1.w_lfsr_state, 16'hB313);

        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_game);
            #1;
            chk("frz_bits1", {12'h0, bits1}, {12'h0, m_lfsr[3:0]});
            chk("frz_bits4", {12'h0, bits4}, {12'h0, m_bits4});
            chk("frz_lfsr", dut1.w_lfsr_state, m_lfsr);
        end
        step_en();
        chk("resume_lfsr", dut1.w_lfsr_state, 16'hED89);

        for (int i = 0; i < 93; i++) step_en();

        // Asynchronous reset between edges, observed before the next edge.
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async_bits1", {12'h0, bits1}, 16'h0001);
        chk("async_bits4", {12'h0, bits4}, 16'h0001);
        chk("async_lfsr", dut1.w_lfsr_state, 16'hACE1);
        enable = 1'b1;
        @(posedge clk_game);
        #1;
        chk("rst_wins_lfsr", dut1.w_lfsr_state, 16'hACE1);
        chk("rst_wins_bits", {12'h0, bits1}, 16'h0001);
        reset = 1'b0;
        step_en();
        step_en();

        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        first_ret = 0;
        zeros     = 0;
        enable    = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            @(posedge clk_game);
            #1;
            if (dut1.w_lfsr_state == 16'h0) zeros++;
            if (dut1.w_lfsr_state == 16'hACE1 && first_ret == 0) first_ret = i;
        end
        chk("period", 16'(first_ret), 16'(65535));
        chk("never_zero", 16'(zeros), 16'h0);

        enable = 1'b0;
        @(posedge clk_game);
        #1;
        force dut1.u_lfsr.r_state = 16'h0;
        #1;
        release dut1.u_lfsr.r_state;
        #1;
        chk("force_hook", dut1.w_lfsr_state, 16'h0);
        enable = 1'b1;
        @(posedge clk_game);
        #1;
        chk("lockup_lfsr", dut1.w_lfsr_state, 16'hACE1);
        chk("lockup_bits", {12'h0, bits1}, 16'h0001);
        enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
